// File: rtl/router_pkg.sv
// router_pkg: shared state encoding, address constants and helpers for the router FSM
package router_pkg;
  localparam int NUM_CH = 3;
  localparam logic [1:0] ADDR_INVALID = 2'd3;
  typedef enum logic [2:0] {
    DECODE_ADDRESS,
    LOAD_FIRST_DATA,
    LOAD_DATA,
    FIFO_FULL_STATE,
    LOAD_AFTER_FULL,
    LOAD_PARITY,
    CHECK_PARITY_ERROR,
    WAIT_TILL_EMPTY
  } state_t;
  function automatic logic [NUM_CH-1:0] onehot(input logic [1:0] a);
    return NUM_CH'(1) << a;
  endfunction
endpackage

// File: rtl/router_fsm_if.sv
// router_fsm_if: packet input, FIFO status and FSM status/strobe bundle
interface router_fsm_if;
  logic                         pkt_valid;
  logic [1:0]                   data_in;
  logic                         parity_done;
  logic                         low_pkt_valid;
  logic [router_pkg::NUM_CH-1:0] fifo_full;
  logic [router_pkg::NUM_CH-1:0] fifo_empty;
  logic [router_pkg::NUM_CH-1:0] read_enb;
  logic [router_pkg::NUM_CH-1:0] write_enb;
  logic [router_pkg::NUM_CH-1:0] soft_reset;
  logic                         detect_add;
  logic                         lfd_state;
  logic                         ld_state;
  logic                         laf_state;
  logic                         full_state;
  logic                         rst_int_reg;
  logic                         busy;
  modport master (
    output pkt_valid, data_in, parity_done, low_pkt_valid, fifo_full, fifo_empty, read_enb,
    input  write_enb, soft_reset, detect_add, lfd_state, ld_state, laf_state, full_state,
           rst_int_reg, busy
  );
  modport slave (
    input  pkt_valid, data_in, parity_done, low_pkt_valid, fifo_full, fifo_empty, read_enb,
    output write_enb, soft_reset, detect_add, lfd_state, ld_state, laf_state, full_state,
           rst_int_reg, busy
  );
endinterface

// File: rtl/router_timeout.sv
// router_timeout: per-channel idle counter; fires a one-cycle flush when a FIFO sits unread too long
module router_timeout #(
  parameter int TIMEOUT = 30
) (
  input  logic clk,
  input  logic reset,
  input  logic empty,
  input  logic read,
  output logic fire
);
  localparam int W = $clog2(TIMEOUT);
  logic [W-1:0] cnt;
  assign fire = cnt == W'(TIMEOUT - 1);
  always_ff @(posedge clk) begin
    cnt <= (reset || empty || read || fire) ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/router_fsm.sv
// router_fsm: Moore packet-routing controller; per-channel timeout flush enabled by ROUTER_FSM_TIMEOUT_EN
module router_fsm
  import router_pkg::*;
#(
  parameter int TIMEOUT = 30
) (
  input logic         clk,
  input logic         reset,
  router_fsm_if.slave bus
);
  state_t     state, next;
  logic [1:0] addr_q;
  logic       hdr_ok;
  logic       full_a;
  assign hdr_ok = bus.pkt_valid && bus.data_in != ADDR_INVALID;
  assign full_a = bus.fifo_full[addr_q];
  always_ff @(posedge clk) begin
    state  <= reset ? DECODE_ADDRESS : next;
    addr_q <= reset ? 2'd0 : (state == DECODE_ADDRESS && hdr_ok) ? bus.data_in : addr_q;
  end
  always_comb begin
    next = state;
    case (state)
      DECODE_ADDRESS:     if (hdr_ok) next = bus.fifo_empty[bus.data_in] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
      LOAD_FIRST_DATA:    next = LOAD_DATA;
      LOAD_DATA:          next = full_a ? FIFO_FULL_STATE : !bus.pkt_valid ? LOAD_PARITY : LOAD_DATA;
      FIFO_FULL_STATE:    if (!full_a) next = LOAD_AFTER_FULL;
      LOAD_AFTER_FULL:    next = bus.parity_done ? DECODE_ADDRESS : bus.low_pkt_valid ? LOAD_PARITY : LOAD_DATA;
      LOAD_PARITY:        next = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: next = full_a ? FIFO_FULL_STATE : DECODE_ADDRESS;
      WAIT_TILL_EMPTY:    if (bus.fifo_empty[addr_q]) next = LOAD_FIRST_DATA;
      default:            next = DECODE_ADDRESS;
    endcase
    if (state != DECODE_ADDRESS && bus.soft_reset[addr_q]) next = DECODE_ADDRESS;
  end
  assign bus.detect_add  = state == DECODE_ADDRESS;
  assign bus.lfd_state   = state == LOAD_FIRST_DATA;
  assign bus.ld_state    = state == LOAD_DATA;
  assign bus.laf_state   = state == LOAD_AFTER_FULL;
  assign bus.full_state  = state == FIFO_FULL_STATE;
  assign bus.rst_int_reg = state == CHECK_PARITY_ERROR;
  assign bus.busy        = !(state == DECODE_ADDRESS || state == LOAD_DATA);
  assign bus.write_enb   = (state == LOAD_DATA || state == LOAD_AFTER_FULL || state == LOAD_PARITY)
                           ? onehot(addr_q) : '0;
`ifdef ROUTER_FSM_TIMEOUT_EN
  for (genvar i = 0; i < NUM_CH; i++) begin : g_to
    router_timeout #(.TIMEOUT(TIMEOUT)) u_to (
      .clk  (clk),
      .reset(reset),
      .empty(bus.fifo_empty[i]),
      .read (bus.read_enb[i]),
      .fire (bus.soft_reset[i])
    );
  end
`else
  logic unused;
  assign unused = ^bus.read_enb ^ (TIMEOUT > 0);
  assign bus.soft_reset = '0;
`endif
endmodule

// File: tb/tb_router_fsm.sv
// tb_router_fsm: directed scenario tests for router_fsm (timeout scenario adapts to ROUTER_FSM_TIMEOUT_EN)
module tb_router_fsm;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  router_fsm_if bus ();
  router_fsm #(.TIMEOUT(30)) dut (.clk(clk), .reset(reset), .bus(bus));
  // {detect_add, lfd, ld, laf, full, rst_int_reg, busy}
  localparam logic [6:0] S_DA   = 7'b1000000;
  localparam logic [6:0] S_LFD  = 7'b0100001;
  localparam logic [6:0] S_LD   = 7'b0010000;
  localparam logic [6:0] S_LAF  = 7'b0001001;
  localparam logic [6:0] S_FULL = 7'b0000101;
  localparam logic [6:0] S_LP   = 7'b0000001;
  localparam logic [6:0] S_CPE  = 7'b0000011;
  localparam logic [6:0] S_WTE  = 7'b0000001;
  logic [6:0] o;
  assign o = {bus.detect_add, bus.lfd_state, bus.ld_state, bus.laf_state, bus.full_state,
              bus.rst_int_reg, bus.busy};
  int checks = 0;
  int passes = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++; if ({o, bus.write_enb} !== {S_DA, 3'b000}) $display("FAIL reset_outs got %b_%b want %b_000", o, bus.write_enb, S_DA); else passes++;
    checks++; if (bus.soft_reset !== 3'b000) $display("FAIL reset_soft got %b want 000", bus.soft_reset); else passes++;
    reset = 1'b0;
    step();
    checks++; if ({o, bus.write_enb} !== {S_DA, 3'b000}) $display("FAIL reset_idle got %b_%b want %b_000", o, bus.write_enb, S_DA); else passes++;
  endtask

  task automatic test_packet();
    logic [7:0] pv = 8'b0000_1111;
    logic [6:0] st [8] = '{S_LFD, S_LD, S_LD, S_LD, S_LD, S_LP, S_CPE, S_DA};
    logic [2:0] we [8] = '{3'b000, 3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b000, 3'b000};
    int n_lfd = 0, n_we = 0, n_rst = 0;
    bus.pkt_valid = 1'b1;
    bus.data_in   = 2'd1;
    for (int k = 0; k < 8; k++) begin
      step();
      checks++; if ({o, bus.write_enb} !== {st[k], we[k]}) $display("FAIL pkt_cyc%0d got %b_%b want %b_%b", k + 1, o, bus.write_enb, st[k], we[k]); else passes++;
      n_lfd += int'(bus.lfd_state);
      n_rst += int'(bus.rst_int_reg);
      n_we  += int'(bus.write_enb == 3'b010);
      bus.pkt_valid = pv[k];
    end
    checks++; if (n_lfd !== 1) $display("FAIL pkt_lfd_cycles got %0d want 1", n_lfd); else passes++;
    checks++; if (n_we !== 5) $display("FAIL pkt_we_cycles got %0d want 5", n_we); else passes++;
    checks++; if (n_rst !== 1) $display("FAIL pkt_rst_cycles got %0d want 1", n_rst); else passes++;
  endtask

  task automatic test_bad_addr();
    bus.pkt_valid = 1'b1;
    bus.data_in   = 2'd3;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if ({o, bus.write_enb} !== {S_DA, 3'b000}) $display("FAIL bad_addr_cyc%0d got %b_%b want %b_000", k, o, bus.write_enb, S_DA); else passes++;
    end
    bus.pkt_valid = 1'b0;
    step();
  endtask

  task automatic test_wait_empty();
    bus.fifo_empty = 3'b011;
    bus.pkt_valid  = 1'b1;
    bus.data_in    = 2'd2;
    step();
    checks++; if ({o, bus.write_enb} !== {S_WTE, 3'b000}) $display("FAIL wte_enter got %b_%b want %b_000", o, bus.write_enb, S_WTE); else passes++;
    bus.pkt_valid = 1'b0;
    step();
    checks++; if ({o, bus.write_enb} !== {S_WTE, 3'b000}) $display("FAIL wte_hold got %b_%b want %b_000", o, bus.write_enb, S_WTE); else passes++;
    bus.fifo_empty = 3'b111;
    step();
    checks++; if ({o, bus.write_enb} !== {S_LFD, 3'b000}) $display("FAIL wte_lfd got %b_%b want %b_000", o, bus.write_enb, S_LFD); else passes++;
    step();
    checks++; if ({o, bus.write_enb} !== {S_LD, 3'b100}) $display("FAIL wte_ld got %b_%b want %b_100", o, bus.write_enb, S_LD); else passes++;
    step();
    checks++; if ({o, bus.write_enb} !== {S_LP, 3'b100}) $display("FAIL wte_lp got %b_%b want %b_100", o, bus.write_enb, S_LP); else passes++;
    step();
    step();
    checks++; if ({o, bus.write_enb} !== {S_DA, 3'b000}) $display("FAIL wte_done got %b_%b want %b_000", o, bus.write_enb, S_DA); else passes++;
  endtask

  task automatic test_fifo_full();
    bus.pkt_valid = 1'b1;
    bus.data_in   = 2'd0;
    step();
    step();
    checks++; if ({o, bus.write_enb} !== {S_LD, 3'b001}) $display("FAIL full_ld got %b_%b want %b_001", o, bus.write_enb, S_LD); else passes++;
    bus.fifo_full = 3'b001;
    step();
    checks++; if ({o, bus.write_enb} !== {S_FULL, 3'b000}) $display("FAIL full_enter got %b_%b want %b_000", o, bus.write_enb, S_FULL); else passes++;
    bus.pkt_valid = 1'b0;
    step();
    checks++; if ({o, bus.write_enb} !== {S_FULL, 3'b000}) $display("FAIL full_hold got %b_%b want %b_000", o, bus.write_enb, S_FULL); else passes++;
    bus.fifo_full     = 3'b000;
    bus.low_pkt_valid = 1'b1;
    step();
    checks++; if ({o, bus.write_enb} !== {S_LAF, 3'b001}) $display("FAIL full_laf got %b_%b want %b_001", o, bus.write_enb, S_LAF); else passes++;
    step();
    checks++; if ({o, bus.write_enb} !== {S_LP, 3'b001}) $display("FAIL full_lp got %b_%b want %b_001", o, bus.write_enb, S_LP); else passes++;
    bus.low_pkt_valid = 1'b0;
    step();
    checks++; if ({o, bus.write_enb} !== {S_CPE, 3'b000}) $display("FAIL full_cpe got %b_%b want %b_000", o, bus.write_enb, S_CPE); else passes++;
    step();
    checks++; if ({o, bus.write_enb} !== {S_DA, 3'b000}) $display("FAIL full_done got %b_%b want %b_000", o, bus.write_enb, S_DA); else passes++;
  endtask

  task automatic test_timeout();
    int early = 0;
    bus.pkt_valid = 1'b1;
    bus.data_in   = 2'd0;
    step();
    bus.fifo_empty = 3'b110;
    bus.read_enb   = 3'b000;
    for (int k = 2; k <= 29; k++) begin
      step();
      early += int'(bus.soft_reset != 3'b000);
    end
    checks++; if (early !== 0) $display("FAIL to_early got %0d pulses want 0", early); else passes++;
    step();
`ifdef ROUTER_FSM_TIMEOUT_EN
    checks++; if ({o, bus.soft_reset} !== {S_LD, 3'b001}) $display("FAIL to_fire got %b_%b want %b_001", o, bus.soft_reset, S_LD); else passes++;
    step();
    checks++; if ({o, bus.soft_reset} !== {S_DA, 3'b000}) $display("FAIL to_flush got %b_%b want %b_000", o, bus.soft_reset, S_DA); else passes++;
`else
    checks++; if ({o, bus.soft_reset} !== {S_LD, 3'b000}) $display("FAIL to_off got %b_%b want %b_000", o, bus.soft_reset, S_LD); else passes++;
    step();
    checks++; if ({o, bus.soft_reset} !== {S_LD, 3'b000}) $display("FAIL to_off2 got %b_%b want %b_000", o, bus.soft_reset, S_LD); else passes++;
`endif
    bus.fifo_empty = 3'b111;
    bus.pkt_valid  = 1'b0;
    for (int k = 0; k < 4; k++) step();
    checks++; if ({o, bus.write_enb} !== {S_DA, 3'b000}) $display("FAIL to_done got %b_%b want %b_000", o, bus.write_enb, S_DA); else passes++;
  endtask

  task automatic test_reset_mid();
    bus.pkt_valid = 1'b1;
    bus.data_in   = 2'd1;
    step();
    step();
    checks++; if ({o, bus.write_enb} !== {S_LD, 3'b010}) $display("FAIL rmid_ld got %b_%b want %b_010", o, bus.write_enb, S_LD); else passes++;
    reset = 1'b1;
    step();
    checks++; if ({o, bus.write_enb, bus.soft_reset} !== {S_DA, 6'b000000}) $display("FAIL rmid_reset got %b_%b_%b want %b_000_000", o, bus.write_enb, bus.soft_reset, S_DA); else passes++;
    reset = 1'b0;
    bus.pkt_valid = 1'b0;
    step();
    checks++; if ({o, bus.write_enb} !== {S_DA, 3'b000}) $display("FAIL rmid_after got %b_%b want %b_000", o, bus.write_enb, S_DA); else passes++;
  endtask

  initial begin
    reset             = 1'b1;
    bus.pkt_valid     = 1'b0;
    bus.data_in       = 2'd0;
    bus.parity_done   = 1'b0;
    bus.low_pkt_valid = 1'b0;
    bus.fifo_full     = 3'b000;
    bus.fifo_empty    = 3'b111;
    bus.read_enb      = 3'b000;
    test_reset();
    test_packet();
    test_bad_addr();
    test_wait_empty();
    test_fifo_full();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired after %0d checks", checks);
    $fatal(1);
  end
endmodule
